prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- Sequences in-system reloading of the 1024 x 18 PicoBlaze instruction BRAM through its port-A byte write enables.
- Receives a framed byte stream over a valid/ready interface (UART or host bridge) and holds the processor in reset while loading.
- Muxes the BRAM address between the processor fetch address and its own write pointer.
- On a good checksum, releases the processor after a fixed delay; on error, keeps it held.

Parameters:
- ADDR_W, 10, instruction address width; max image = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start byte, recognised only in IDLE/ERROR.
- RELEASE_CYCLES, 4, clocks cpu_reset stays high after a good checksum (range 1..255).

Ports:
- clk  in  1  system clock; BRAM and processor share it.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts byte; transfer = rx_valid & rx_ready.
- cpu_address  in  ADDR_W  processor fetch address.
- mem_address  out  ADDR_W  to BRAM address (word address).
- mem_din  out  18  to BRAM {DIPA[1:0],DIA[15:0]}.
- mem_we  out  4  to BRAM WEA.
- cpu_reset  out  1  processor reset, active-high.
- load_busy  out  1  high whenever state != IDLE.
- load_done  out  1  one-cycle pulse on successful release.
- load_error  out  1  sticky error flag.

Behaviour:
- Async reset values: state=IDLE, cpu_reset=0 (processor runs the existing image), rx_ready=1, mem_we=0, load_busy=0, load_done=0, load_error=0, ptr=0, csum=0.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then LEN words of 3 bytes each (B2,B1,B0), then CSUM.
- Word value = {B2[1:0],B1,B0}. B2[7:2] is ignored.
- csum = XOR of all bytes after SYNC, including the length bytes.
- States: IDLE, LEN_HI, LEN_LO, B2, B1, B0, WRITE, CSUM, RELEASE, ERROR.
- IDLE:
  - rx_ready=1. Non-sync bytes are discarded.
  - Accepted SYNC_BYTE: next cycle cpu_reset=1, ptr=0, csum=0, load_error=0, state LEN_HI.
- LEN_HI, LEN_LO: latch the 16-bit length (big-endian).
  - After LEN_LO, length 0 or > 2**ADDR_W goes to ERROR. Otherwise store remaining = LEN-1 and go to B2.
- B2 -> B1 -> B0: each advances on an accepted byte. B0 goes to WRITE.
- WRITE (exactly 1 cycle):
  - rx_ready=0, mem_we=4'b0011, mem_address=ptr, mem_din=assembled word.
  - Then ptr++. If remaining==0 go to CSUM, else decrement remaining and go to B2.
- CSUM: on accepted byte, if byte==csum go to RELEASE, else go to ERROR.
- RELEASE:
  - rx_ready=0; a counter runs RELEASE_CYCLES clocks.
  - On the final count: cpu_reset=0, load_done=1 for one cycle, state IDLE.
- ERROR:
  - cpu_reset=1, load_error=1, rx_ready=1.
  - Non-sync bytes are discarded. SYNC_BYTE restarts as in IDLE.
- Inside a frame, SYNC_BYTE value is plain data (no resync).
- Address mux (combinational, zero latency):
  - IDLE: mem_address=cpu_address.
  - All other states: mem_address=ptr.
- mem_we=0 in every state except WRITE. mem_din=0 outside WRITE.
- ptr wraps naturally at 2**ADDR_W. A full 1024-word load ends with ptr=0.
- Backpressure: in WRITE/RELEASE, rx_valid held high is not consumed. The byte transfers on the first cycle rx_ready returns high.
- rst_n asserted mid-load: immediate return to IDLE with cpu_reset=0. The partially written image is not protected; the system reset owner must reload.

Decomposition:
- Shared package prog_loader_pkg holds:
  - state enum
  - SYNC_BYTE default
  - WE_INSTR=4'b0011
  - frame-length limit
- No sub-module: FSM, counters and XOR accumulator sit in one block. The BRAM wrapper is instantiated alongside it, not inside it.

Test Plan:
- Good 2-word load: bytes A5,00,02,00,F3,FE,02,00,00,0D
  - Writes addr0=0x0F3FE, then addr1=0x20000, each with mem_we=0011 for one cycle.
  - cpu_reset high from the cycle after A5 until RELEASE_CYCLES after 0D; load_done pulses once; load_error=0.
- Bad checksum: same frame ending 0E
  - load_error=1, cpu_reset stays 1.
  - A following good frame clears load_error and releases the processor.
- Length bounds:
  - LEN=0x0000 → ERROR right after LEN_LO, with no write.
  - LEN=0x0401 → ERROR.
  - LEN=0x0400 with 1024 words → writes 0..1023, then release.
- Idle passthrough: stream 00,FF,5A
  - All discarded; cpu_reset=0; mem_we=0.
  - mem_address tracks cpu_address in the same cycle.
- Backpressure: rx_valid held continuously during WRITE
  - rx_ready=0 for that cycle; no byte is lost or duplicated; written data matches the stream.
- Reset mid-load: rst_n pulsed low after the first word is written
  - IDLE, cpu_reset=0, load_busy=0, mem_address=cpu_address.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the PicoBlaze program-memory loader.
package prog_loader_pkg;

    // Loader sequencing states; one per byte position in the frame plus bookkeeping states.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_B2,
        ST_B1,
        ST_B0,
        ST_WRITE,
        ST_CSUM,
        ST_RELEASE,
        ST_ERROR
    } load_state_e;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Port-A byte enables covering DIA[15:0] and DIPA[1:0] of the 18-bit instruction word.
    localparam logic [3:0] WE_INSTR = 4'b0011;

    // Default instruction address width (1024-word memory).
    localparam int ADDR_W_DEF = 10;

    // A frame length is usable when it is non-zero and fits the instruction memory.
    function automatic logic len_in_range(input logic [15:0] len, input int unsigned addr_w);
        return (len != 16'd0) && ({16'd0, len} <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/prog_mem_loader.sv
// In-system reloader for the PicoBlaze instruction BRAM: parses a framed byte
// stream, writes each 18-bit word through port A, checks an XOR checksum and
// holds the processor in reset until a good image has been loaded.
module prog_mem_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W         = ADDR_W_DEF,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         RELEASE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_address,
    output logic [ADDR_W-1:0] mem_address,
    output logic [17:0]       mem_din,
    output logic [3:0]        mem_we,
    output logic              cpu_reset,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [7:0] REL_LAST = 8'(RELEASE_CYCLES - 1);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [1:0]        b2_q, b2_d;
    logic [7:0]        b1_q, b1_d;
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        rel_cnt_q, rel_cnt_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;

    logic              xfer;
    logic [15:0]       len_word;
    logic              is_sync;

    // Byte acceptance is a pure decode of the state: the loader stalls only while writing or releasing.
    assign rx_ready  = (state_q != ST_WRITE) && (state_q != ST_RELEASE);
    assign xfer      = rx_valid && rx_ready;
    assign is_sync   = (rx_data == SYNC_BYTE);
    assign len_word  = {len_hi_q, rx_data};

    // The processor owns the BRAM address only while the loader is idle.
    assign mem_address = (state_q == ST_IDLE) ? cpu_address : ptr_q;
    assign mem_we      = (state_q == ST_WRITE) ? WE_INSTR : 4'b0000;
    assign mem_din     = (state_q == ST_WRITE) ? {b2_q, b1_q, b0_q} : 18'd0;

    assign load_busy  = (state_q != ST_IDLE);
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

    // Next-state, datapath and flag computation for the frame parser.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        remaining_d  = remaining_q;
        csum_d       = csum_q;
        len_hi_d     = len_hi_q;
        b2_d         = b2_q;
        b1_d         = b1_q;
        b0_d         = b0_q;
        rel_cnt_d    = rel_cnt_q;
        cpu_reset_d  = cpu_reset_q;
        load_done_d  = 1'b0;
        load_error_d = load_error_q;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                // Only a sync byte starts a frame; anything else is dropped.
                if (xfer && is_sync) begin
                    state_d      = ST_LEN_HI;
                    cpu_reset_d  = 1'b1;
                    ptr_d        = '0;
                    csum_d       = 8'd0;
                    load_error_d = 1'b0;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = rx_data;
                    csum_d   = csum_q ^ rx_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    csum_d = csum_q ^ rx_data;
                    if (len_in_range(len_word, ADDR_W)) begin
                        remaining_d = ADDR_W'(len_word - 16'd1);
                        state_d     = ST_B2;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = ST_ERROR;
                    end
                end
            end
            ST_B2: begin
                if (xfer) begin
                    b2_d    = rx_data[1:0];
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_B1;
                end
            end
            ST_B1: begin
                if (xfer) begin
                    b1_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_B0;
                end
            end
            ST_B0: begin
                if (xfer) begin
                    b0_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The BRAM write itself happens this cycle via the decoded mem_we.
                ptr_d = ptr_q + ADDR_W'(1);
                if (remaining_q == '0) begin
                    state_d = ST_CSUM;
                end else begin
                    remaining_d = remaining_q - ADDR_W'(1);
                    state_d     = ST_B2;
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (rx_data == csum_q) begin
                        rel_cnt_d = 8'd0;
                        state_d   = ST_RELEASE;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = ST_ERROR;
                    end
                end
            end
            ST_RELEASE: begin
                if (rel_cnt_q == REL_LAST) begin
                    cpu_reset_d = 1'b0;
                    load_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    rel_cnt_d = rel_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset lets the processor run the existing image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            remaining_q  <= '0;
            csum_q       <= 8'd0;
            len_hi_q     <= 8'd0;
            b2_q         <= 2'd0;
            b1_q         <= 8'd0;
            b0_q         <= 8'd0;
            rel_cnt_q    <= 8'd0;
            cpu_reset_q  <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            remaining_q  <= remaining_d;
            csum_q       <= csum_d;
            len_hi_q     <= len_hi_d;
            b2_q         <= b2_d;
            b1_q         <= b1_d;
            b0_q         <= b0_d;
            rel_cnt_q    <= rel_cnt_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: framed loads, error paths, backpressure and reset.
module tb_prog_mem_loader;

    localparam int ADDR_W = 10;
    localparam int REL    = 4;

    logic              clk;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] cpu_address;
    logic [ADDR_W-1:0] mem_address;
    logic [17:0]       mem_din;
    logic [3:0]        mem_we;
    logic              cpu_reset;
    logic              load_busy;
    logic              load_done;
    logic              load_error;

    int checks   = 0;
    int failures = 0;
    int done_count = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] we;
    } wr_t;
    wr_t wq[$];

    prog_mem_loader #(
        .ADDR_W         (ADDR_W),
        .SYNC_BYTE      (8'hA5),
        .RELEASE_CYCLES (REL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cpu_address (cpu_address),
        .mem_address (mem_address),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .cpu_reset   (cpu_reset),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every BRAM write cycle and count completion pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we != 4'd0) wq.push_back('{32'(mem_address), 32'(mem_din), 32'(mem_we)});
        if (load_done) done_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a byte and hold rx_valid until it transfers; rx_valid stays high afterwards.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        $display("tx byte %02h  busy=%0b cpu_reset=%0b err=%0b", b, load_busy, cpu_reset, load_error);
    endtask

    task automatic idle_line();
        rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!load_done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(load_done), 32'd1);
    endtask

    logic [7:0] good2[10] = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'hF3, 8'hFE, 8'h02, 8'h00, 8'h00, 8'h0D};

    initial begin
        logic [7:0] cs;
        logic [7:0] b2, b1, b0;
        int bad;
        int d0;

        rst_n = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; cpu_address = 10'h155;
        #12;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        check("rst_addr_mux", 32'(mem_address), 32'h155);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle passthrough: non-sync bytes dropped, address follows the processor.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        idle_line();
        check("idle_cpu_reset", 32'(cpu_reset), 32'd0);
        check("idle_busy", 32'(load_busy), 32'd0);
        check("idle_no_write", 32'(wq.size()), 32'd0);
        cpu_address = 10'h2AA; #1;
        check("idle_addr_track", 32'(mem_address), 32'h2AA);

        // Good two-word frame, streamed with rx_valid held high throughout.
        send_byte(good2[0]);
        check("good_reset_after_sync", 32'(cpu_reset), 32'd1);
        check("good_busy", 32'(load_busy), 32'd1);
        for (int i = 1; i < 6; i++) send_byte(good2[i]);
        check("write_rx_ready", 32'(rx_ready), 32'd0);
        check("write_we", 32'(mem_we), 32'h3);
        check("write_addr0", 32'(mem_address), 32'd0);
        check("write_din0", 32'(mem_din), 32'h0F3FE);
        for (int i = 6; i < 10; i++) send_byte(good2[i]);
        rx_valid = 1'b0;
        check("release_rx_ready", 32'(rx_ready), 32'd0);
        for (int i = 0; i < REL - 1; i++) begin
            @(posedge clk); #1;
            check("release_hold", 32'(cpu_reset), 32'd1);
        end
        @(posedge clk); #1;
        check("release_cpu_reset", 32'(cpu_reset), 32'd0);
        check("release_done", 32'(load_done), 32'd1);
        check("release_busy", 32'(load_busy), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(load_done), 32'd0);
        check("good_error", 32'(load_error), 32'd0);
        check("good_nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check("good_w0_addr", wq[0].addr, 32'd0);
            check("good_w0_data", wq[0].data, 32'h0F3FE);
            check("good_w0_we", wq[0].we, 32'h3);
            check("good_w1_addr", wq[1].addr, 32'd1);
            check("good_w1_data", wq[1].data, 32'h20000);
            check("good_w1_we", wq[1].we, 32'h3);
        end
        wq.delete();

        // Bad checksum keeps the processor held and flags the error.
        for (int i = 0; i < 9; i++) send_byte(good2[i]);
        send_byte(8'h0E);
        idle_line(); idle_line();
        check("bad_error", 32'(load_error), 32'd1);
        check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        check("bad_rx_ready", 32'(rx_ready), 32'd1);
        send_byte(8'h33);
        check("err_discard", 32'(load_error), 32'd1);
        // Recovery frame.
        d0 = done_count;
        send_byte(good2[0]);
        check("recover_clear_error", 32'(load_error), 32'd0);
        for (int i = 1; i < 10; i++) send_byte(good2[i]);
        rx_valid = 1'b0;
        wait_done("recover_done");
        check("recover_cpu_reset", 32'(cpu_reset), 32'd0);
        idle_line();
        check("recover_done_count", 32'(done_count - d0), 32'd1);
        wq.delete();

        // Length zero and length over the memory size.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        idle_line();
        check("len0_error", 32'(load_error), 32'd1);
        check("len0_no_write", 32'(wq.size()), 32'd0);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        idle_line();
        check("len401_error", 32'(load_error), 32'd1);
        check("len401_cpu_reset", 32'(cpu_reset), 32'd1);

        // Full 1024-word image; upper bits of B2 are junk and must be ignored.
        cpu_address = 10'h3FF;
        cs = 8'h04 ^ 8'h00;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
        for (int i = 0; i < 1024; i++) begin
            b2 = 8'hFC | 8'(i >> 8);
            b1 = 8'(i) ^ 8'h5A;
            b0 = 8'(i * 3);
            cs = cs ^ b2 ^ b1 ^ b0;
            rx_data = b2; send_byte(b2);
            send_byte(b1);
            send_byte(b0);
        end
        send_byte(cs);
        rx_valid = 1'b0;
        check("full_ptr_wrap", 32'(mem_address), 32'd0);
        wait_done("full_done");
        check("full_nwrites", 32'(wq.size()), 32'd1024);
        bad = 0;
        for (int i = 0; i < wq.size() && i < 1024; i++) begin
            if (wq[i].addr != 32'(i)) bad++;
            if (wq[i].data != {14'd0, 2'(i >> 8), 8'(i) ^ 8'h5A, 8'(i * 3)}) bad++;
        end
        check("full_contents_bad", 32'(bad), 32'd0);
        check("full_error", 32'(load_error), 32'd0);
        wq.delete();

        // Reset during a load, after the first word has been written.
        cpu_address = 10'h0C3;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_wrote", 32'(wq.size()), 32'd1);
        rst_n = 1'b0; #1;
        check("midrst_busy", 32'(load_busy), 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd0);
        check("midrst_addr_mux", 32'(mem_address), 32'h0C3);
        check("midrst_error", 32'(load_error), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
